// File: rtl/pipe_hazard_scoreboard.sv
// RAW hazard detection and EXE forwarding-select unit over DEPTH in-flight stages; selects are registered (1 cycle).
// Optional build macro HDU_ZERO_REG_IGNORE_EN: ignore matches on destination register 0.
module pipe_hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int DEPTH       = 2,
    parameter int FORW_SEL_W  = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   forward_EN,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  src1_ID,
    input  logic [REG_ADDR_W-1:0]  src2_ID,
    input  logic                   is_imm,
    input  logic                   ST_or_BNE,
    input  logic [REG_ADDR_W-1:0]  dest_ID,
    input  logic                   WB_EN_ID,
    input  logic                   MEM_R_EN_ID,
    input  logic                   flush,
    input  logic                   cnt_clr,
    output logic                   hazard_detected,
    output logic [FORW_SEL_W-1:0]  val1_sel,
    output logic [FORW_SEL_W-1:0]  val2_sel,
    output logic [FORW_SEL_W-1:0]  ST_val_sel,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [DEPTH-1:0]      sb_v;
    logic [DEPTH-1:0]      sb_wb;
    logic [DEPTH-1:0]      sb_ld;
    logic [REG_ADDR_W-1:0] sb_dest [DEPTH];

    logic [DEPTH-1:0]      live;
    logic [DEPTH-1:0]      match1;
    logic [DEPTH-1:0]      match2;
    logic                  use2;
    logic                  load_ok;
    logic [FORW_SEL_W-1:0] nxt_val1_sel;
    logic [FORW_SEL_W-1:0] nxt_val2_sel;
    logic [FORW_SEL_W-1:0] nxt_st_sel;

    // Lowest index is the youngest producer, so it is applied last and wins.
    function automatic logic [FORW_SEL_W-1:0] youngest(input logic [DEPTH-1:0] m);
        logic [FORW_SEL_W-1:0] sel;
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m[k]) sel = FORW_SEL_W'(k + 1);
        end
        return sel;
    endfunction

    always_comb begin
        use2 = !is_imm || ST_or_BNE;
        for (int k = 0; k < DEPTH; k++) begin
`ifdef HDU_ZERO_REG_IGNORE_EN
            live[k] = sb_v[k] && sb_wb[k] && (sb_dest[k] != '0);
`else
            live[k] = sb_v[k] && sb_wb[k];
`endif
            match1[k] = live[k] && (sb_dest[k] == src1_ID);
            match2[k] = live[k] && use2 && (sb_dest[k] == src2_ID);
        end
    end

    always_comb begin
        if (forward_EN)
            hazard_detected = id_valid && (match1[0] || match2[0]) && sb_ld[0];
        else
            hazard_detected = id_valid && ((|match1) || (|match2));
        load_ok = id_valid && !flush && !hazard_detected;
    end

    always_comb begin
        nxt_val1_sel = '0;
        nxt_val2_sel = '0;
        nxt_st_sel   = '0;
        if (forward_EN && load_ok) begin
            nxt_val1_sel = youngest(match1);
            nxt_val2_sel = is_imm    ? '0 : youngest(match2);
            nxt_st_sel   = ST_or_BNE ? youngest(match2) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v       <= '0;
            sb_wb      <= '0;
            sb_ld      <= '0;
            for (int k = 0; k < DEPTH; k++) sb_dest[k] <= '0;
            val1_sel   <= '0;
            val2_sel   <= '0;
            ST_val_sel <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_v[k]    <= sb_v[k-1];
                sb_wb[k]   <= sb_wb[k-1];
                sb_ld[k]   <= sb_ld[k-1];
                sb_dest[k] <= sb_dest[k-1];
            end
            sb_v[0]    <= load_ok;
            sb_wb[0]   <= WB_EN_ID;
            sb_ld[0]   <= MEM_R_EN_ID;
            sb_dest[0] <= dest_ID;
            val1_sel   <= nxt_val1_sel;
            val2_sel   <= nxt_val2_sel;
            ST_val_sel <= nxt_st_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (hazard_detected && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scenario bench for pipe_hazard_scoreboard (DEPTH=2, 2-bit stall counter).
module tb_pipe_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_EN;
    logic       id_valid;
    logic [4:0] src1_ID, src2_ID, dest_ID;
    logic       is_imm, ST_or_BNE, WB_EN_ID, MEM_R_EN_ID, flush, cnt_clr;
    logic       hazard_detected;
    logic [1:0] val1_sel, val2_sel, ST_val_sel;
    logic [1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      nm;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] st;
    } sel_exp_t;

    sel_exp_t exp_q[$];

    pipe_hazard_scoreboard #(
        .REG_ADDR_W(5), .DEPTH(2), .FORW_SEL_W(2), .STALL_CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .forward_EN(forward_EN), .id_valid(id_valid),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .is_imm(is_imm), .ST_or_BNE(ST_or_BNE),
        .dest_ID(dest_ID), .WB_EN_ID(WB_EN_ID), .MEM_R_EN_ID(MEM_R_EN_ID),
        .flush(flush), .cnt_clr(cnt_clr), .hazard_detected(hazard_detected),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .ST_val_sel(ST_val_sel),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // One ID cycle: check the combinational stall, queue the select expectation, check it after the edge.
    task automatic issue(input string nm, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic imm, input logic stb, input logic [4:0] d, input logic wb,
                         input logic ld, input logic fl, input logic eh,
                         input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] es);
        sel_exp_t e;
        id_valid = v; src1_ID = s1; src2_ID = s2; is_imm = imm; ST_or_BNE = stb;
        dest_ID = d; WB_EN_ID = wb; MEM_R_EN_ID = ld; flush = fl;
        #1;
        n_vec++;
        if (hazard_detected !== eh) begin
            n_err++;
            $display("FAIL %s hazard: got %b want %b", nm, hazard_detected, eh);
        end
        e.nm = nm; e.s1 = e1; e.s2 = e2; e.st = es;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s sel_queue: got empty want entry", nm);
        end else begin
            e = exp_q.pop_front();
            if ({val1_sel, val2_sel, ST_val_sel} !== {e.s1, e.s2, e.st}) begin
                n_err++;
                $display("FAIL %s sels(v1,v2,st): got %0d,%0d,%0d want %0d,%0d,%0d",
                         e.nm, val1_sel, val2_sel, ST_val_sel, e.s1, e.s2, e.st);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_cnt(input string nm, input logic [1:0] want);
        n_vec++;
        if (stall_cnt !== want) begin
            n_err++;
            $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, want);
        end
    endtask

    task automatic clear_cnt;
        id_valid = 1'b0; cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_cnt("cnt_clr", 2'd0);
    endtask

    task automatic test_reset;
        rst = 1'b1; forward_EN = 1'b0; id_valid = 1'b0; src1_ID = '0; src2_ID = '0;
        dest_ID = '0; is_imm = 1'b0; ST_or_BNE = 1'b0; WB_EN_ID = 1'b0;
        MEM_R_EN_ID = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({hazard_detected, val1_sel, val2_sel, ST_val_sel, stall_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_state: got haz=%b sels=%0d,%0d,%0d cnt=%0d want all 0",
                     hazard_detected, val1_sel, val2_sel, ST_val_sel, stall_cnt);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_stall_no_fwd;
        forward_EN = 1'b0;
        clear_cnt();
        issue("nf_add_r3", 1, 1, 2, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        issue("nf_sub_st1", 1, 3, 6, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0);
        issue("nf_sub_st2", 1, 3, 6, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0);
        issue("nf_sub_go", 1, 3, 6, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        check_cnt("nf_stall_cnt", 2'd2);
        idle(2);
    endtask

    task automatic test_forwarding;
        forward_EN = 1'b1;
        issue("fw_add_r3", 1, 1, 2, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        issue("fw_use_mem", 1, 3, 9, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0);
        idle(2);
        issue("fw_add_r3b", 1, 1, 2, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        issue("fw_unrel", 1, 11, 12, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);
        issue("fw_use_wb", 1, 3, 9, 0, 0, 10, 1, 0, 0, 0, 2, 0, 0);
        idle(2);
    endtask

    task automatic test_load_use;
        forward_EN = 1'b1;
        clear_cnt();
        issue("lu_ld_r4", 1, 1, 2, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        issue("lu_add_stall", 1, 1, 4, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0);
        issue("lu_add_go", 1, 1, 4, 0, 0, 5, 1, 0, 0, 0, 0, 2, 0);
        check_cnt("lu_stall_cnt", 2'd1);
        idle(2);
        issue("lu_ld_r4b", 1, 1, 2, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        issue("lu_imm_nouse", 1, 1, 4, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
    endtask

    task automatic test_store;
        forward_EN = 1'b1;
        issue("st_add_r5", 1, 1, 2, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        issue("st_store", 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
    endtask

    task automatic test_youngest_and_flush;
        forward_EN = 1'b1;
        issue("yw_add_r7a", 1, 1, 2, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        issue("yw_add_r7b", 1, 1, 2, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        issue("yw_use_r7", 1, 7, 7, 0, 0, 8, 1, 0, 0, 0, 1, 1, 0);
        idle(2);
        clear_cnt();
        issue("fl_ld_r3", 1, 1, 2, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        issue("fl_ld_flushed", 1, 3, 2, 1, 0, 9, 1, 1, 1, 1, 0, 0, 0);
        issue("fl_use_r9", 1, 9, 2, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0);
        check_cnt("fl_stall_cnt", 2'd1);
        idle(2);
    endtask

    task automatic test_back_to_back;
        forward_EN = 1'b0;
        clear_cnt();
        issue("bb_add_r3", 1, 1, 2, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            issue("bb_stall1", 1, 3, 6, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0);
            issue("bb_stall2", 1, 3, 6, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0);
            issue("bb_go", 1, 3, 6, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        end
        check_cnt("bb_saturated", 2'd3);
        idle(2);
        clear_cnt();
    endtask

    task automatic test_reset_mid;
        forward_EN = 1'b1;
        issue("rm_add_r3", 1, 1, 2, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        issue("rm_ld_r4", 1, 3, 2, 1, 0, 4, 1, 1, 0, 0, 1, 0, 0);
        id_valid = 1'b1; src1_ID = 5'd4; src2_ID = 5'd9; is_imm = 1'b0; ST_or_BNE = 1'b0;
        dest_ID = 5'd5; WB_EN_ID = 1'b1; MEM_R_EN_ID = 1'b0; flush = 1'b0;
        #1;
        n_vec++;
        if (hazard_detected !== 1'b1) begin
            n_err++;
            $display("FAIL rm_pre_hazard: got %b want 1", hazard_detected);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({hazard_detected, val1_sel, val2_sel, ST_val_sel, stall_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL rm_in_reset: got haz=%b sels=%0d,%0d,%0d cnt=%0d want all 0",
                     hazard_detected, val1_sel, val2_sel, ST_val_sel, stall_cnt);
        end
        #1;
        rst = 1'b0;
        id_valid = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
    endtask

    task automatic test_zero_reg;
        forward_EN = 1'b0;
        issue("zr_add_r0", 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef HDU_ZERO_REG_IGNORE_EN
        issue("zr_use_r0", 1, 0, 6, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
`else
        issue("zr_use_r0_st1", 1, 0, 6, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0);
        issue("zr_use_r0_st2", 1, 0, 6, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0);
        issue("zr_use_r0_go", 1, 0, 6, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
`endif
        idle(2);
    endtask

    initial begin
        test_reset();
        test_stall_no_fwd();
        test_forwarding();
        test_load_use();
        test_store();
        test_youngest_and_flush();
        test_back_to_back();
        test_reset_mid();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
